// File: rtl/galetron_sched_pkg.sv
// Shared definitions for the process scheduler: FSM encoding and the PC limit
// below which code is treated as OS space and does not consume the quantum.
// No ports; imported by process_scheduler.
package galetron_sched_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    SELECT  = 2'd2,
    REQUEST = 2'd3
  } state_t;

  // Program counters below this value belong to the OS and are not billed.
  localparam logic [11:0] OS_PC_LIMIT = 12'd256;

endpackage

// File: rtl/rr_picker.sv
// Round-robin picker: first set bit of mask searching upward from start, with wrap.
// Ports: mask (candidates), start (first slot examined), index (winner).
// Purely combinational; when mask is empty the slot just before start is returned.
module rr_picker #(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] mask,
  input  logic [W-1:0] start,
  output logic [W-1:0] index
);

  always_comb begin
    // start-1 is the slot the search wraps back to last, so an empty mask
    // lands on it as well; the caller passes current+1, giving "stay put".
    index = start - W'(1);
    // Walk from the far end so the lowest offset from start wins.
    for (int k = N - 1; k >= 0; k--) begin
      if (mask[start + W'(k)]) begin
        index = start + W'(k);
      end
    end
  end

endmodule

// File: rtl/process_scheduler.sv
// Quantum-based preemptive scheduler: counts user-space retires, then picks the
// next runnable process round-robin and requests a context exchange until acked.
// Ports: clock/reset_n; enable; quantum_load/quantum_value; instruction_retired;
//   program_counter; ready_mask; exchange_ack; context_exchange; output_watchdog;
//   current_process; next_process; switch_count when SCHED_SWITCH_COUNT_EN is defined.
// Latency: context_exchange rises one edge after the expiring retire's edge.
// Backpressure: REQUEST holds context_exchange until exchange_ack is seen.
module process_scheduler
  import galetron_sched_pkg::*;
#(
  parameter int N_PROC = 8,
  parameter int QW     = 32
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      enable,
  input  logic                      quantum_load,
  input  logic [QW-1:0]             quantum_value,
  input  logic                      instruction_retired,
  input  logic [11:0]               program_counter,
  input  logic [N_PROC-1:0]         ready_mask,
  input  logic                      exchange_ack,
  output logic                      context_exchange,
  output logic [QW-1:0]             output_watchdog,
  output logic [$clog2(N_PROC)-1:0] current_process,
`ifdef SCHED_SWITCH_COUNT_EN
  output logic [15:0]               switch_count,
`endif
  output logic [$clog2(N_PROC)-1:0] next_process
);

  localparam int PW = $clog2(N_PROC);

  state_t        state_q, state_d;
  logic [QW-1:0] quantum_q, quantum_d;
  logic [QW-1:0] wd_q, wd_d;
  logic [PW-1:0] cur_q, cur_d;
  logic [PW-1:0] nxt_q, nxt_d;

  logic [PW-1:0] pick_start;
  logic [PW-1:0] pick_idx;
  logic [QW-1:0] reload_val;
  logic          counted;
  logic          ack_accept;

  assign pick_start = cur_q + PW'(1);

  rr_picker #(.N(N_PROC)) u_picker (
    .mask  (ready_mask),
    .start (pick_start),
    .index (pick_idx)
  );

  // A load on the same edge as a reload wins and its value is used directly.
  assign reload_val = quantum_load ? quantum_value : quantum_q;
  assign counted    = instruction_retired && (program_counter >= OS_PC_LIMIT) && (wd_q != '0);
  assign ack_accept = enable && (state_q == REQUEST) && exchange_ack;

  always_comb begin
    state_d   = state_q;
    quantum_d = quantum_load ? quantum_value : quantum_q;
    wd_d      = wd_q;
    cur_d     = cur_q;
    nxt_d     = nxt_q;
    if (!enable) begin
      state_d = IDLE;
      wd_d    = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = RUN;
          wd_d    = reload_val;
        end
        RUN: begin
          // A zero quantum never counts, so RUN is never left.
          if (counted) begin
            wd_d = wd_q - QW'(1);
            if (wd_q == QW'(1)) state_d = SELECT;
          end
        end
        SELECT: begin
          nxt_d   = pick_idx;
          state_d = REQUEST;
        end
        REQUEST: begin
          if (exchange_ack) begin
            cur_d   = nxt_q;
            wd_d    = reload_val;
            state_d = RUN;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      quantum_q <= '0;
      wd_q      <= '0;
      cur_q     <= '0;
      nxt_q     <= '0;
    end else begin
      state_q   <= state_d;
      quantum_q <= quantum_d;
      wd_q      <= wd_d;
      cur_q     <= cur_d;
      nxt_q     <= nxt_d;
    end
  end

  // Decoded from state so reset drops the request without waiting for an edge.
  assign context_exchange = (state_q == REQUEST);
  assign output_watchdog  = wd_q;
  assign current_process  = cur_q;
  assign next_process     = nxt_q;

`ifdef SCHED_SWITCH_COUNT_EN
  logic [15:0] swc_q, swc_d;

  always_comb begin
    swc_d = swc_q;
    if (ack_accept) swc_d = swc_q + 16'd1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) swc_q <= '0;
    else          swc_q <= swc_d;
  end

  assign switch_count = swc_q;
`else
  logic unused_ack_accept;
  assign unused_ack_accept = ack_accept;
`endif

endmodule

// File: tb/tb_process_scheduler.sv
// Scoreboard bench for process_scheduler: stimulus pushes expectations into
// queues, a negedge monitor pops them on context_exchange edges and on probes.
module tb_process_scheduler;
  import galetron_sched_pkg::*;

  localparam int N_PROC = 8;
  localparam int QW     = 32;

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic              enable = 1'b0;
  logic              quantum_load = 1'b0;
  logic [QW-1:0]     quantum_value = '0;
  logic              instruction_retired = 1'b0;
  logic [11:0]       program_counter = '0;
  logic [N_PROC-1:0] ready_mask = '0;
  logic              exchange_ack = 1'b0;
  logic              context_exchange;
  logic [QW-1:0]     output_watchdog;
  logic [2:0]        current_process;
  logic [2:0]        next_process;
`ifdef SCHED_SWITCH_COUNT_EN
  logic [15:0]       switch_count;
`endif

  process_scheduler #(.N_PROC(N_PROC), .QW(QW)) dut (
    .clock               (clock),
    .reset_n             (reset_n),
    .enable              (enable),
    .quantum_load        (quantum_load),
    .quantum_value       (quantum_value),
    .instruction_retired (instruction_retired),
    .program_counter     (program_counter),
    .ready_mask          (ready_mask),
    .exchange_ack        (exchange_ack),
    .context_exchange    (context_exchange),
    .output_watchdog     (output_watchdog),
    .current_process     (current_process),
`ifdef SCHED_SWITCH_COUNT_EN
    .switch_count        (switch_count),
`endif
    .next_process        (next_process)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc++;

  typedef struct { int nxt; int cyc; } rise_t;
  typedef struct { int cur; int wd; int swc; } ack_t;
  typedef struct { int wd; int cx; int cur; int nxt; int st; int swc; } probe_t;

  rise_t  rise_q[$];
  ack_t   ack_q[$];
  probe_t probe_q[$];
  string  probe_name_q[$];

  int n_tests = 0;
  int n_fail  = 0;
  int exp_cur = 0;
  int exp_nxt = 0;
  int exp_swc = 0;

  function automatic void chk(string nm, int act, int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endfunction

  // ---------------- monitor ----------------
  logic cx_prev = 1'b0;
  always @(negedge clock) begin
    rise_t  r;
    ack_t   a;
    probe_t p;
    string  nm;
    if (context_exchange && !cx_prev) begin
      if (rise_q.size() == 0) begin
        chk("unexpected_rise", 1, 0);
      end else begin
        r = rise_q.pop_front();
        chk("rise_next_process", int'(next_process), r.nxt);
        chk("rise_cycle", cyc, r.cyc);
      end
    end
    if (!context_exchange && cx_prev && reset_n) begin
      if (ack_q.size() == 0) begin
        chk("unexpected_fall", 1, 0);
      end else begin
        a = ack_q.pop_front();
        chk("ack_current_process", int'(current_process), a.cur);
        chk("ack_watchdog", int'(output_watchdog), a.wd);
`ifdef SCHED_SWITCH_COUNT_EN
        chk("ack_switch_count", int'(switch_count), a.swc);
`endif
      end
    end
    while (probe_q.size() > 0) begin
      p  = probe_q.pop_front();
      nm = probe_name_q.pop_front();
      chk({nm, ".watchdog"}, int'(output_watchdog), p.wd);
      chk({nm, ".cx"}, int'(context_exchange), p.cx);
      chk({nm, ".current"}, int'(current_process), p.cur);
      chk({nm, ".next"}, int'(next_process), p.nxt);
      chk({nm, ".state"}, int'(dut.state_q), p.st);
`ifdef SCHED_SWITCH_COUNT_EN
      chk({nm, ".switch_count"}, int'(switch_count), p.swc);
`endif
    end
    cx_prev = context_exchange;
  end

  // ---------------- stimulus ----------------
  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic probe(input string nm, input int wd, input int cx, input state_t st);
    probe_q.push_back('{wd, cx, exp_cur, exp_nxt, int'(st), exp_swc});
    probe_name_q.push_back(nm);
  endtask

  // Burn n_ret user retires to expire the quantum, hold REQUEST, then ack.
  task automatic do_switch(input int n_ret, input int nxt, input int wd_after,
                           input bit ld, input int ld_val);
    program_counter = 12'd300;
    for (int i = 0; i < n_ret; i++) begin
      instruction_retired = 1'b1;
      tick();
    end
    instruction_retired = 1'b0;
    // Expiring edge enters SELECT; the following edge enters REQUEST.
    rise_q.push_back('{nxt, cyc + 1});
    tick();
    exp_nxt = nxt;
    tick();
    probe("hold_request", 0, 1, REQUEST);
    exchange_ack = 1'b1;
    if (ld) begin
      quantum_load  = 1'b1;
      quantum_value = QW'(ld_val);
    end
    exp_cur = nxt;
    exp_swc++;
    ack_q.push_back('{nxt, wd_after, exp_swc});
    tick();
    exchange_ack = 1'b0;
    quantum_load = 1'b0;
  endtask

  initial begin
    tick();
    tick();
    probe("reset", 0, 0, IDLE);
    tick();
    reset_n = 1'b1;

    // Quantum 3, mask 0x06, user space: three retires then switch to 1.
    quantum_load  = 1'b1;
    quantum_value = 32'd3;
    tick();
    quantum_load    = 1'b0;
    ready_mask      = 8'h06;
    program_counter = 12'd300;
    enable          = 1'b1;
    tick();
    probe("run_entry", 3, 0, RUN);
    do_switch(3, 1, 3, 1'b0, 0);
    probe("after_ack1", 3, 0, RUN);

    // Disable keeps current_process, clears the watchdog.
    enable = 1'b0;
    tick();
    probe("disable", 0, 0, IDLE);

    // Quantum 4; OS-space retires do not count, stray acks ignored.
    quantum_load  = 1'b1;
    quantum_value = 32'd4;
    tick();
    quantum_load = 1'b0;
    enable       = 1'b1;
    tick();
    probe("reload4", 4, 0, RUN);
    program_counter     = 12'd100;
    instruction_retired = 1'b1;
    exchange_ack        = 1'b1;
    repeat (5) tick();
    instruction_retired = 1'b0;
    exchange_ack        = 1'b0;
    tick();
    probe("os_space", 4, 0, RUN);

    // A new quantum does not disturb the running count.
    quantum_load  = 1'b1;
    quantum_value = 32'd1;
    tick();
    quantum_load = 1'b0;
    probe("load_no_effect", 4, 0, RUN);

    ready_mask = 8'h80;
    do_switch(4, 7, 1, 1'b0, 0);   // 1 -> 7, reload picks up quantum 1
    ready_mask = 8'h00;
    do_switch(1, 7, 5, 1'b1, 5);   // empty mask stays on 7; load on ack edge
    ready_mask = 8'h81;
    do_switch(5, 0, 5, 1'b0, 0);   // search from 7+1 wraps to 0

    // Quantum 0 disables preemption entirely.
    quantum_load  = 1'b1;
    quantum_value = 32'd0;
    tick();
    quantum_load = 1'b0;
    enable       = 1'b0;
    tick();
    enable = 1'b1;
    tick();
    probe("q0_entry", 0, 0, RUN);
    program_counter     = 12'd300;
    instruction_retired = 1'b1;
    repeat (1000) tick();
    instruction_retired = 1'b0;
    tick();
    probe("q0_hold", 0, 0, RUN);

    // Asynchronous reset in the middle of REQUEST.
    quantum_load  = 1'b1;
    quantum_value = 32'd2;
    tick();
    quantum_load = 1'b0;
    enable       = 1'b0;
    tick();
    enable = 1'b1;
    tick();
    probe("q2_entry", 2, 0, RUN);
    ready_mask          = 8'h06;
    instruction_retired = 1'b1;
    tick();
    tick();
    instruction_retired = 1'b0;
    rise_q.push_back('{1, cyc + 1});
    tick();
    exp_nxt = 1;
    probe("pre_reset", 0, 1, REQUEST);
    tick();
    reset_n = 1'b0;
    exp_cur = 0;
    exp_nxt = 0;
    exp_swc = 0;
    probe("async_reset", 0, 0, IDLE);
    tick();
    tick();
    enable  = 1'b0;
    reset_n = 1'b1;
    tick();
    tick();

    chk("rise_q_drained", rise_q.size(), 0);
    chk("ack_q_drained", ack_q.size(), 0);
    chk("probe_q_drained", probe_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/process_scheduler.md
PROCESS_SCHEDULER -- requirements
Module: process_scheduler

Interface
REQ-001 SHALL have parameter N_PROC, default 8, number of process slots (power of two, 2..16).
REQ-002 SHALL have parameter QW, default 32, quantum counter width.
REQ-003 SHALL have port clock  in  1  single clock, all state changes on its rising edge.
REQ-004 SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port enable  in  1  scheduling on when high.
REQ-006 SHALL have port quantum_load  in  1  one-cycle write strobe for quantum_value.
REQ-007 SHALL have port quantum_value  in  QW  instructions per quantum; 0 disables preemption.
REQ-008 SHALL have port instruction_retired  in  1  one pulse per executed instruction.
REQ-009 SHALL have port program_counter  in  12  current PC; PC < 256 is OS space.
REQ-010 SHALL have port ready_mask  in  N_PROC  bit i high means process i is runnable.
REQ-011 SHALL have port exchange_ack  in  1  OS has saved context and accepts next_process.
REQ-012 SHALL have port context_exchange  out  1  context-switch request to reset_controller.
REQ-013 SHALL have port output_watchdog  out  QW  remaining quantum count.
REQ-014 SHALL have port current_process  out  log2(N_PROC)  running process index.
REQ-015 SHALL have port next_process  out  log2(N_PROC)  selected successor.

Function
REQ-016 SHALL implement FSM states IDLE, RUN, SELECT, REQUEST.
REQ-017 SHALL leave IDLE for RUN on the first edge with enable=1, loading output_watchdog from the quantum register.
REQ-018 SHALL, in RUN, decrement output_watchdog by 1 per edge with instruction_retired=1, program_counter >= 256 and output_watchdog != 0.
REQ-019 SHALL not count while program_counter < 256.
REQ-020 SHALL, on a counted retire with output_watchdog=1, set output_watchdog=0 and enter SELECT at that edge.
REQ-021 SHALL, when the quantum is 0, hold output_watchdog at 0, never leave RUN and never raise context_exchange.
REQ-022 SHALL, in SELECT, register next_process as the first set ready_mask bit searching round-robin from current_process+1 with wrap, then enter REQUEST one edge later.
REQ-023 SHALL set next_process=current_process when no other bit is set, including ready_mask=0.
REQ-024 SHALL hold context_exchange=1 for the whole REQUEST state, asserted from the edge after SELECT: 2 edges after the expiring retire.
REQ-025 SHALL, on an edge in REQUEST with exchange_ack=1, set current_process=next_process, reload output_watchdog, drop context_exchange and enter RUN.
REQ-026 SHALL ignore exchange_ack outside REQUEST.
REQ-027 SHALL update the quantum register on quantum_load from any state; it applies at the next reload, not to the running count.
REQ-028 SHALL apply a quantum_load in preference to a reload on the same edge, using the new value.
REQ-029 SHALL, on enable=0 in any state, enter IDLE next edge, clear context_exchange and output_watchdog and keep current_process.

Reset
REQ-030 SHALL on reset_n=0 immediately force IDLE, context_exchange=0, output_watchdog=0, current_process=0, next_process=0 and quantum register=0.

Configuration
REQ-031 SHALL, with SCHED_SWITCH_COUNT_EN defined, add output switch_count (16 bits, reset 0), incremented on each accepted exchange_ack and wrapping 0xFFFF->0.
REQ-032 SHALL, without SCHED_SWITCH_COUNT_EN, have no switch_count port and no counter logic.

Structure
REQ-033 SHALL place the FSM state encoding and the OS_PC_LIMIT=256 constant in shared package galetron_sched_pkg.
REQ-034 SHALL implement the round-robin search as sub-module rr_picker, combinational inputs mask and start and output index.

Verification
REQ-035 SHALL check: quantum 3, ready_mask 0x06, PC 300, three retires -> context_exchange rises 2 edges after the third retire; next_process=1; ack -> current_process=1, output_watchdog=3.
REQ-036 SHALL check: quantum 4, retires with PC 100 -> output_watchdog stays 4.
REQ-037 SHALL check: current 7, ready_mask 0x81 -> next_process 0 (wrap); ready_mask 0x00 -> next_process 7.
REQ-038 SHALL check: quantum 0 and 1000 user retires -> context_exchange never asserts, output_watchdog=0.
REQ-039 SHALL check: reset_n pulled low mid-REQUEST -> context_exchange=0 without a clock edge; state IDLE.
REQ-040 SHALL check: quantum_load of 5 on the ack edge -> output_watchdog=5; with SCHED_SWITCH_COUNT_EN, switch_count increments by 1.
